otn_tx_sched: RTL and testbench

- Transmit-side scheduler that sequences the frame position counter (fpc) and chooses the byte source for each frame column.
- Sources by column:
  - Overhead, columns 0-15.
  - Payload client stream, columns 16-1039.
  - Per-row BIP-8 parity, column 1040.
- Drives the fpc advance strobe and the fpc hold strobe. Sits between the client payload FIFO, the overhead generator, and the line serializer.

---
 rtl/otn_tx_sched.sv | 134 +++++++++++++
 tb/tb_otn_tx_sched.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otn_tx_sched.sv
// OTN transmit column scheduler: picks the overhead, payload or BIP-8 byte for each fpc
// position and paces the external frame position counter through advance/hold strobes.
module otn_tx_sched #(
   parameter int OH_COLS  = 16,
   parameter int LAST_COL = 1040,
   parameter int DW       = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_en,
   input  logic [1:0]    i_row_cnt,
   input  logic [10:0]   i_col_cnt,
   output logic          o_fpc_valid,
   output logic          o_fpc_retrans_req,
   input  logic          i_line_retrans_req,
   output logic [5:0]    o_oh_idx,
   input  logic [DW-1:0] i_oh_data,
   input  logic          i_pl_valid,
   input  logic [DW-1:0] i_pl_data,
   output logic          o_pl_ready,
   output logic          o_valid,
   output logic [DW-1:0] o_data,
   output logic [1:0]    o_sel,
   output logic          o_frame_start,
   output logic [15:0]   o_frame_cnt
);

   typedef enum logic [2:0] {IDLE, OH, PAYLOAD, PARITY, HOLD} state_t;

   state_t        state, ret_state;
   logic [DW-1:0] acc;
   logic          consume;
   logic          at_origin, oh_end, pl_end, last_row;
   logic [DW-1:0] byte_mux;
   logic [1:0]    sel_mux;

   assign o_oh_idx  = 6'(32'(i_row_cnt) * OH_COLS + 32'(i_col_cnt));
   assign at_origin = (i_row_cnt == 2'd0) && (i_col_cnt == 11'd0);
   assign oh_end    = (i_col_cnt == 11'(OH_COLS - 1));
   assign pl_end    = (i_col_cnt == 11'(LAST_COL - 1));
   assign last_row  = (i_row_cnt == 2'd3);

   // Hold request masks the advance strobe in the very cycle it rises.
   assign o_pl_ready = (state == PAYLOAD) && !i_line_retrans_req;

   always_comb begin
      consume = 1'b0;
      case (state)
         OH, PARITY: consume = !i_line_retrans_req;
         PAYLOAD:    consume = i_pl_valid && !i_line_retrans_req;
         default:    consume = 1'b0;
      endcase
   end

   assign o_fpc_valid = consume;

   always_comb begin
      byte_mux = i_oh_data;
      sel_mux  = 2'd0;
      if (state == PAYLOAD) begin
         byte_mux = i_pl_data;
         sel_mux  = 2'd1;
      end else if (state == PARITY) begin
         byte_mux = acc;
         sel_mux  = 2'd2;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state             <= IDLE;
         ret_state         <= OH;
         acc               <= '0;
         o_frame_cnt       <= 16'd0;
         o_valid           <= 1'b0;
         o_data            <= '0;
         o_sel             <= 2'd0;
         o_frame_start     <= 1'b0;
         o_fpc_retrans_req <= 1'b0;
      end else begin
         o_valid       <= consume;
         o_data        <= consume ? byte_mux : '0;
         o_sel         <= consume ? sel_mux : 2'd0;
         o_frame_start <= consume && (state == OH) && at_origin;

         // Parity column emits the row's XOR and restarts accumulation in one step.
         if (consume && state == PAYLOAD) acc <= acc ^ i_pl_data;
         if (consume && state == PARITY)  acc <= '0;

         case (state)
            IDLE: begin
               o_fpc_retrans_req <= 1'b1;
               if (i_en && at_origin) begin
                  state             <= OH;
                  o_fpc_retrans_req <= 1'b0;
               end
            end
            HOLD: begin
               if (!i_line_retrans_req) begin
                  state             <= ret_state;
                  o_fpc_retrans_req <= 1'b0;
               end
            end
            OH, PAYLOAD, PARITY: begin
               if (i_line_retrans_req) begin
                  state             <= HOLD;
                  ret_state         <= state;
                  o_fpc_retrans_req <= 1'b1;
               end else if (consume) begin
                  case (state)
                     OH:      if (oh_end) state <= PAYLOAD;
                     PAYLOAD: if (pl_end) state <= PARITY;
                     default: begin
                        if (!last_row) begin
                           state <= OH;
                        end else begin
                           o_frame_cnt <= o_frame_cnt + 16'd1;
                           if (i_en) begin
                              state <= OH;
                           end else begin
                              state             <= IDLE;
                              o_fpc_retrans_req <= 1'b1;
                           end
                        end
                     end
                  endcase
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_otn_tx_sched.sv
// Directed bench for otn_tx_sched: models the external fpc, a payload source and an
// overhead source, and checks the emitted byte stream frame by frame.
module tb_otn_tx_sched;

   localparam int FRAME = 4164;
   localparam int ROWL  = 1041;

   logic        clk = 1'b0;
   logic        rst, en, line_req, pl_valid, pl_mode;
   int          a4_row, a4_col;
   logic [1:0]  row;
   logic [10:0] col;
   logic        fpc_valid, fpc_retrans, pl_ready, o_valid, o_frame_start;
   logic [5:0]  oh_idx;
   logic [7:0]  oh_data, pl_data, o_data;
   logic [1:0]  o_sel;
   logic [15:0] frame_cnt;

   logic [10:0] outq[$];
   int          n_retrans = 0;
   int          n_consume = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   otn_tx_sched dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_row_cnt(row), .i_col_cnt(col),
      .o_fpc_valid(fpc_valid), .o_fpc_retrans_req(fpc_retrans),
      .i_line_retrans_req(line_req), .o_oh_idx(oh_idx), .i_oh_data(oh_data),
      .i_pl_valid(pl_valid), .i_pl_data(pl_data), .o_pl_ready(pl_ready),
      .o_valid(o_valid), .o_data(o_data), .o_sel(o_sel),
      .o_frame_start(o_frame_start), .o_frame_cnt(frame_cnt)
   );

   function automatic logic [7:0] pl_byte(input logic m, input int r, input int c,
                                          input int ar, input int ac);
      if (!m) return 8'(c);
      return (r == ar && c == ac) ? 8'hA4 : 8'hA5;
   endfunction

   assign oh_data = {2'b10, oh_idx};
   assign pl_data = pl_byte(pl_mode, int'(row), int'(col), a4_row, a4_col);

   // External frame position counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row <= 2'd0;
         col <= 11'd0;
      end else if (fpc_valid) begin
         if (col == 11'd1040) begin
            col <= 11'd0;
            row <= row + 2'd1;
         end else begin
            col <= col + 11'd1;
         end
      end
   end

   always @(negedge clk) begin
      if (o_valid) outq.push_back({o_sel, o_data, o_frame_start});
      if (fpc_retrans) n_retrans <= n_retrans + 1;
      if (fpc_valid) n_consume <= n_consume + 1;
   end

   // Counts bytes deviating from the frame layout: OH = 0x80|idx, payload, then row XOR.
   function automatic int frame_errs(input int start, input int nbytes, input logic m,
                                     input int ar, input int ac);
      int errs, pos, r, c;
      logic [7:0] par, want;
      logic [1:0] s;
      errs = 0;
      par  = 8'h00;
      for (int i = 0; i < nbytes; i++) begin
         pos = i % FRAME;
         r   = pos / ROWL;
         c   = pos % ROWL;
         if (c == 0) par = 8'h00;
         if (c < 16) begin
            s = 2'd0; want = 8'h80 | 8'(r * 16 + c);
         end else if (c < 1040) begin
            s = 2'd1; want = pl_byte(m, r, c, ar, ac); par ^= want;
         end else begin
            s = 2'd2; want = par;
         end
         if (outq[start + i] !== {s, want, pos == 0}) errs++;
      end
      return errs;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_pos(input int r, input int c, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 10000; k++) begin
         if (row == 2'(r) && col == 11'(c)) begin
            ok = 1'b1;
            break;
         end
         cyc();
      end
   endtask

   task automatic wait_frames(input int target, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 10000; k++) begin
         if (frame_cnt == 16'(target)) begin
            ok = 1'b1;
            break;
         end
         cyc();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b0; line_req = 1'b0; pl_valid = 1'b0; pl_mode = 1'b0;
      a4_row = -1; a4_col = -1;
      repeat (3) cyc();
      checks++;
      if ({o_valid, o_data, o_sel, o_frame_start} !== 12'd0) begin
         errors++; $display("FAIL reset_out: valid/data/sel/fs=%h want 0", {o_valid, o_data, o_sel, o_frame_start});
      end
      checks++;
      if ({pl_ready, fpc_valid, fpc_retrans} !== 3'b000) begin
         errors++; $display("FAIL reset_strobes: ready/fpcv/retrans=%b want 000", {pl_ready, fpc_valid, fpc_retrans});
      end
      checks++;
      if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: %0d want 0", frame_cnt); end
      rst = 1'b1;
      cyc(); cyc();
      checks++;
      if (fpc_retrans !== 1'b1 || fpc_valid !== 1'b0 || o_valid !== 1'b0) begin
         errors++; $display("FAIL idle_strobes: retrans=%b fpcv=%b valid=%b want 1 0 0", fpc_retrans, fpc_valid, o_valid);
      end
   endtask

   task automatic test_frame();
      int q0, c0, q1, e;
      bit ok;
      q0 = outq.size(); c0 = n_consume;
      pl_valid = 1'b1; en = 1'b1;
      wait_frames(1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL frame1_done: timeout, frame_cnt=%0d want 1", frame_cnt); end
      checks++;
      if (n_consume - c0 !== FRAME) begin errors++; $display("FAIL frame1_consumes: %0d want %0d", n_consume - c0, FRAME); end
      wait_pos(1, 200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL frame2_pos: timeout at row %0d col %0d want 1/200", row, col); end
      en = 1'b0;
      wait_frames(2, ok);
      repeat (3) cyc();
      checks++;
      if (!ok || frame_cnt !== 16'd2) begin errors++; $display("FAIL frame2_done: frame_cnt=%0d want 2", frame_cnt); end
      checks++;
      if (outq.size() - q0 !== 2 * FRAME) begin errors++; $display("FAIL frame_bytes: %0d valid bytes want %0d", outq.size() - q0, 2 * FRAME); end
      e = frame_errs(q0, 2 * FRAME, 1'b0, -1, -1);
      checks++;
      if (e !== 0) begin errors++; $display("FAIL frame_content: %0d wrong bytes want 0", e); end
      checks++;
      if (fpc_retrans !== 1'b1 || row !== 2'd0 || col !== 11'd0) begin
         errors++; $display("FAIL idle_hold: retrans=%b pos=%0d/%0d want 1 0/0", fpc_retrans, row, col);
      end
      q1 = outq.size();
      repeat (20) cyc();
      checks++;
      if (outq.size() !== q1) begin errors++; $display("FAIL idle_quiet: %0d bytes in idle want 0", outq.size() - q1); end
   endtask

   task automatic test_parity();
      logic [7:0] par_want [4] = '{8'h00, 8'h01, 8'h00, 8'h00};
      int q0, e;
      bit ok;
      pl_mode = 1'b1; a4_row = 1; a4_col = 700;
      q0 = outq.size();
      en = 1'b1;
      repeat (10) cyc();
      en = 1'b0;
      wait_frames(3, ok);
      repeat (3) cyc();
      checks++;
      if (!ok || outq.size() - q0 !== FRAME) begin errors++; $display("FAIL parity_frame: %0d bytes want %0d", outq.size() - q0, FRAME); end
      for (int r = 0; r < 4; r++) begin
         checks++;
         if (outq[q0 + r * ROWL + 1040] !== {2'd2, par_want[r], 1'b0}) begin
            errors++; $display("FAIL parity_row%0d: got %h want sel 2 byte %h", r, outq[q0 + r * ROWL + 1040], par_want[r]);
         end
      end
      e = frame_errs(q0, FRAME, 1'b1, 1, 700);
      checks++;
      if (e !== 0) begin errors++; $display("FAIL parity_content: %0d wrong bytes want 0", e); end
      pl_mode = 1'b0; a4_row = -1; a4_col = -1;
   endtask

   task automatic test_stall();
      int q0, e;
      bit ok;
      q0 = outq.size();
      en = 1'b1;
      wait_pos(0, 500, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL stall_pos: timeout want col 500"); end
      pl_valid = 1'b0;
      #1;
      checks++;
      if (fpc_valid !== 1'b0) begin errors++; $display("FAIL stall_fpcv0: %b want 0", fpc_valid); end
      repeat (4) begin
         cyc();
         checks++;
         if (fpc_valid !== 1'b0 || o_valid !== 1'b0) begin
            errors++; $display("FAIL stall_quiet: fpcv=%b valid=%b want 0 0", fpc_valid, o_valid);
         end
      end
      cyc();
      checks++;
      if (o_valid !== 1'b0 || col !== 11'd500) begin errors++; $display("FAIL stall_hold: valid=%b col=%0d want 0 500", o_valid, col); end
      pl_valid = 1'b1;
      #1;
      checks++;
      if (fpc_valid !== 1'b1) begin errors++; $display("FAIL stall_resume: fpcv=%b want 1", fpc_valid); end
      en = 1'b0;
      cyc();
      checks++;
      if ({o_valid, o_sel, o_data} !== {1'b1, 2'd1, 8'hF4}) begin
         errors++; $display("FAIL stall_byte: valid/sel/data=%b/%0d/%h want 1/1/f4", o_valid, o_sel, o_data);
      end
      wait_frames(4, ok);
      repeat (3) cyc();
      e = frame_errs(q0, FRAME, 1'b0, -1, -1);
      checks++;
      if (!ok || outq.size() - q0 !== FRAME || e !== 0) begin
         errors++; $display("FAIL stall_frame: %0d bytes, %0d wrong, want %0d and 0", outq.size() - q0, e, FRAME);
      end
   endtask

   task automatic hold_at(input int c, input logic [1:0] s, input logic [7:0] d);
      int r0;
      bit ok;
      wait_pos(0, c, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL hold_pos: timeout want col %0d", c); end
      r0 = n_retrans;
      line_req = 1'b1;
      #1;
      checks++;
      if (fpc_valid !== 1'b0 || pl_ready !== 1'b0) begin
         errors++; $display("FAIL hold_mask_c%0d: fpcv=%b ready=%b want 0 0", c, fpc_valid, pl_ready);
      end
      cyc(); cyc(); cyc();
      line_req = 1'b0;
      cyc();
      #1;
      checks++;
      if (col !== 11'(c) || fpc_valid !== 1'b1) begin
         errors++; $display("FAIL hold_replay_c%0d: col=%0d fpcv=%b want %0d 1", c, col, fpc_valid, c);
      end
      cyc();
      checks++;
      if ({o_valid, o_sel, o_data} !== {1'b1, s, d}) begin
         errors++; $display("FAIL hold_byte_c%0d: valid/sel/data=%b/%0d/%h want 1/%0d/%h", c, o_valid, o_sel, o_data, s, d);
      end
      checks++;
      if (n_retrans - r0 !== 3) begin errors++; $display("FAIL hold_retrans_c%0d: %0d cycles want 3", c, n_retrans - r0); end
   endtask

   task automatic test_hold();
      int q0, e;
      bit ok;
      q0 = outq.size();
      en = 1'b1;
      hold_at(7, 2'd0, 8'h87);
      hold_at(300, 2'd1, 8'h2C);
      en = 1'b0;
      wait_frames(5, ok);
      repeat (3) cyc();
      e = frame_errs(q0, FRAME, 1'b0, -1, -1);
      checks++;
      if (!ok || outq.size() - q0 !== FRAME || e !== 0) begin
         errors++; $display("FAIL hold_frame: %0d bytes, %0d wrong, want %0d and 0", outq.size() - q0, e, FRAME);
      end
   endtask

   task automatic test_reset_mid();
      int q0, e;
      bit ok;
      pl_mode = 1'b1;
      en = 1'b1;
      wait_pos(2, 601, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rmid_pos: timeout want row 2 col 601"); end
      rst = 1'b0;
      #1;
      checks++;
      if ({o_valid, o_data, o_sel, o_frame_start, pl_ready, fpc_valid, fpc_retrans} !== 15'd0) begin
         errors++; $display("FAIL rmid_outputs: %h want 0", {o_valid, o_data, o_sel, o_frame_start, pl_ready, fpc_valid, fpc_retrans});
      end
      checks++;
      if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rmid_frame_cnt: %0d want 0", frame_cnt); end
      en = 1'b0;
      cyc(); cyc();
      rst = 1'b1;
      q0 = outq.size();
      cyc();
      en = 1'b1;
      repeat (5) cyc();
      en = 1'b0;
      wait_frames(1, ok);
      repeat (3) cyc();
      checks++;
      if (!ok || frame_cnt !== 16'd1) begin errors++; $display("FAIL rmid_count: frame_cnt=%0d want 1", frame_cnt); end
      e = frame_errs(q0, FRAME, 1'b1, -1, -1);
      checks++;
      if (outq.size() - q0 !== FRAME || e !== 0) begin
         errors++; $display("FAIL rmid_frame: %0d bytes, %0d wrong, want %0d and 0", outq.size() - q0, e, FRAME);
      end
      pl_mode = 1'b0;
   endtask

   initial begin
      test_reset();
      test_frame();
      test_parity();
      test_stall();
      test_hold();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
